// File: rtl/gpio_seg_scan_if.sv
// Signal bundle between a segment-byte source and the gpio_seg_scan display scanner.
// The master is the source of segment bytes and controls. The slave is the scanner.
// Optional feature macro: GPIO_SEG_DIM_EN adds the 4-bit brightness control.
interface gpio_seg_scan_if;
  logic       enable;
  logic [7:0] seg_0;
  logic [7:0] seg_1;
  logic [7:0] seg_2;
  logic [7:0] seg_3;
  logic [7:0] seg_4;
  logic [7:0] seg_5;
  logic [7:0] seg_6;
  logic [7:0] seg_7;
  logic [7:0] digit_mask;
`ifdef GPIO_SEG_DIM_EN
  logic [3:0] brightness;
`endif
  logic [7:0] scan_an;
  logic [7:0] scan_seg;
  logic       frame_start;

  modport master (
`ifdef GPIO_SEG_DIM_EN
    output brightness,
`endif
    output enable, seg_0, seg_1, seg_2, seg_3, seg_4, seg_5, seg_6, seg_7, digit_mask,
    input  scan_an, scan_seg, frame_start
  );

  modport slave (
`ifdef GPIO_SEG_DIM_EN
    input  brightness,
`endif
    input  enable, seg_0, seg_1, seg_2, seg_3, seg_4, seg_5, seg_6, seg_7, digit_mask,
    output scan_an, scan_seg, frame_start
  );
endinterface

// File: rtl/gpio_seg_scan.sv
// gpio_seg_scan: time-multiplexes eight seven-segment bytes onto one shared segment bus.
// The bus is paired with eight digit-enable lines.
// All digits are snapshotted at each frame start so a frame never tears.
// Each digit slot begins with a blank window so the previous digit does not ghost.
// Optional feature macro: GPIO_SEG_DIM_EN adds PWM dimming within each DRIVE window.
module gpio_seg_scan #(
  parameter int CLK_DIV       = 1000,
  parameter int BLANK_CYC     = 16,
  parameter bit AN_ACTIVE_LOW = 1'b1,
  parameter bit SEG_INV       = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  gpio_seg_scan_if.slave  bus
);

  localparam int             CNT_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [7:0]     AN_OFF     = AN_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0]     SEG_XOR    = SEG_INV ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_DRIVE} state_t;

  // A zero-length blank window means every slot starts directly in DRIVE.
  localparam state_t SLOT_ENTRY = (BLANK_CYC == 0) ? ST_DRIVE : ST_BLANK;

  state_t           r_state;
  logic [2:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_shadow [8];
  logic [7:0]       r_an;
  logic [7:0]       r_seg;
  logic             r_fs;

  logic [7:0]       w_seg_in [8];
  state_t           w_nxt_state;
  logic [2:0]       w_nxt_idx;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic             w_snap;
  logic             w_nxt_fs;
  logic [7:0]       w_seg_sel;
  logic [7:0]       w_onehot;
  logic             w_lit;
`ifdef GPIO_SEG_DIM_EN
  logic [3:0]       w_phase;
`endif

  assign w_seg_in[0] = bus.seg_0;
  assign w_seg_in[1] = bus.seg_1;
  assign w_seg_in[2] = bus.seg_2;
  assign w_seg_in[3] = bus.seg_3;
  assign w_seg_in[4] = bus.seg_4;
  assign w_seg_in[5] = bus.seg_5;
  assign w_seg_in[6] = bus.seg_6;
  assign w_seg_in[7] = bus.seg_7;

  assign bus.scan_an     = r_an;
  assign bus.scan_seg    = r_seg;
  assign bus.frame_start = r_fs;

  // Next-state, slot position and snapshot decision for the coming cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_cnt   = r_cnt;
    w_snap      = 1'b0;
    w_nxt_fs    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.enable) begin
          w_nxt_state = SLOT_ENTRY;
          w_nxt_idx   = 3'd0;
          w_nxt_cnt   = '0;
          w_snap      = 1'b1;
          w_nxt_fs    = 1'b1;
        end
      end
      ST_BLANK: begin
        w_nxt_cnt = r_cnt + 1'b1;
        if (r_cnt == BLANK_LAST) w_nxt_state = ST_DRIVE;
      end
      ST_DRIVE: begin
        w_nxt_cnt = r_cnt + 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_nxt_cnt   = '0;
          w_nxt_idx   = r_idx + 3'd1;
          w_nxt_state = SLOT_ENTRY;
          // Digit 7 wrapping to digit 0 starts a new frame.
          if (r_idx == 3'd7) begin
            w_snap   = 1'b1;
            w_nxt_fs = 1'b1;
          end
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
    // Disable overrides everything; shadow contents are kept.
    if (!bus.enable) begin
      w_nxt_state = ST_IDLE;
      w_nxt_idx   = 3'd0;
      w_nxt_cnt   = '0;
      w_snap      = 1'b0;
      w_nxt_fs    = 1'b0;
    end
  end

  // Output data for the coming cycle; a fresh snapshot must be visible immediately.
  always_comb begin
    w_seg_sel = w_snap ? w_seg_in[w_nxt_idx] : r_shadow[w_nxt_idx];
    w_onehot  = 8'd1 << w_nxt_idx;
    w_lit     = bus.digit_mask[w_nxt_idx];
`ifdef GPIO_SEG_DIM_EN
    w_phase   = 4'(32'(w_nxt_cnt) - 32'(BLANK_CYC));
    w_lit     = w_lit && (w_phase < bus.brightness);
`endif
  end

  // Scanner FSM with registered digit enables, segment bus and frame pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_idx    <= 3'd0;
      r_cnt    <= '0;
      // NOTE: the shadow array is small and must read as blank after reset, so it is reset.
      r_shadow <= '{default: 8'h00};
      r_an     <= AN_OFF;
      r_seg    <= SEG_XOR;
      r_fs     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_state <= w_nxt_state;
      r_idx   <= w_nxt_idx;
      r_cnt   <= w_nxt_cnt;
      r_fs    <= w_nxt_fs;
      if (w_snap) r_shadow <= w_seg_in;
      if (w_nxt_state == ST_DRIVE) begin
        r_seg <= w_seg_sel ^ SEG_XOR;
        r_an  <= w_lit ? (AN_ACTIVE_LOW ? ~w_onehot : w_onehot) : AN_OFF;
      end else begin
        r_seg <= SEG_XOR;
        r_an  <= AN_OFF;
      end
    end
  end

endmodule

// File: tb/tb_gpio_seg_scan.sv
// Self-checking bench for gpio_seg_scan.
// It uses a frame-position reference model with a per-cycle expected-output queue.
// It also uses a vector table for reset and start-up, plus hand-written multi-cycle sequences.
// Optional feature macro: GPIO_SEG_DIM_EN selects the dimming configuration (CLK_DIV=34).
module tb_gpio_seg_scan;
`ifdef GPIO_SEG_DIM_EN
  localparam int CLK_DIV = 34;
`else
  localparam int CLK_DIV = 8;
`endif
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = 8 * CLK_DIV;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seg;
    logic       fs;
  } exp_t;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [7:0] an;
    logic [7:0] seg;
    logic       fs;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] mask;
  logic [7:0] seg [8];
  logic [3:0] bright;

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb [$];
  bit         m_run = 1'b0;
  int         m_t   = 0;
  logic [7:0] m_sh [8];

  gpio_seg_scan_if bus ();

  assign bus.enable     = enable;
  assign bus.digit_mask = mask;
  assign bus.seg_0      = seg[0];
  assign bus.seg_1      = seg[1];
  assign bus.seg_2      = seg[2];
  assign bus.seg_3      = seg[3];
  assign bus.seg_4      = seg[4];
  assign bus.seg_5      = seg[5];
  assign bus.seg_6      = seg[6];
  assign bus.seg_7      = seg[7];
`ifdef GPIO_SEG_DIM_EN
  assign bus.brightness = bright;
`endif

  gpio_seg_scan #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYC    (BLANK_CYC),
    .AN_ACTIVE_LOW(1'b1),
    .SEG_INV      (1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference model: position within the frame decides every output.
  task automatic model_edge(output exp_t e);
    int  slot;
    int  pos;
    bit  lit;
    e = '{an: 8'hFF, seg: 8'hFF, fs: 1'b0};
    if (!reset) begin
      m_run = 1'b0;
      m_t   = 0;
      for (int k = 0; k < 8; k++) m_sh[k] = 8'h00;
    end else if (!enable) begin
      m_run = 1'b0;
    end else begin
      if (!m_run) begin
        m_run = 1'b1;
        m_t   = 0;
      end else begin
        m_t = (m_t + 1) % FRAME;
      end
      if (m_t == 0) for (int k = 0; k < 8; k++) m_sh[k] = seg[k];
      slot = m_t / CLK_DIV;
      pos  = m_t % CLK_DIV;
      e.fs = (m_t == 0);
      if (pos >= BLANK_CYC) begin
        e.seg = ~m_sh[slot];
        lit   = mask[slot];
`ifdef GPIO_SEG_DIM_EN
        lit   = lit && (((pos - BLANK_CYC) % 16) < int'(bright));
`endif
        if (lit) e.an = ~(8'd1 << slot);
      end
    end
  endtask

  // One clock: push the expectation, advance, then pop and compare the DUT outputs.
  task automatic step();
    exp_t e;
    exp_t got;
    model_edge(e);
    sb.push_back(e);
    @(posedge clock);
    #1;
    e   = sb.pop_front();
    got = '{an: bus.scan_an, seg: bus.scan_seg, fs: bus.frame_start};
    check($sformatf("cycle t=%0d run=%0d {an,seg,fs}", m_t, m_run), 32'(got), 32'(e));
  endtask

  task automatic run_to(input int target);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(m_run && m_t == target) && n < 2 * FRAME + 8);
    if (!(m_run && m_t == target)) check($sformatf("reach t=%0d", target), 32'(m_t), 32'(target));
  endtask

  vec_t vecs [7];

  initial begin
    int cnt;
    int lit;

    reset  = 1'b0;
    enable = 1'b1;
    mask   = 8'hFF;
    bright = 4'd15;
    for (int k = 0; k < 8; k++) seg[k] = 8'(k + 1);

    // Reset holds outputs off; release starts a frame with two blank cycles, then digit 0.
    vecs[0] = '{rst_n: 1'b0, en: 1'b1, an: 8'hFF, seg: 8'hFF, fs: 1'b0};
    vecs[1] = '{rst_n: 1'b0, en: 1'b1, an: 8'hFF, seg: 8'hFF, fs: 1'b0};
    vecs[2] = '{rst_n: 1'b0, en: 1'b1, an: 8'hFF, seg: 8'hFF, fs: 1'b0};
    vecs[3] = '{rst_n: 1'b1, en: 1'b1, an: 8'hFF, seg: 8'hFF, fs: 1'b1};
    vecs[4] = '{rst_n: 1'b1, en: 1'b1, an: 8'hFF, seg: 8'hFF, fs: 1'b0};
    vecs[5] = '{rst_n: 1'b1, en: 1'b1, an: 8'hFE, seg: 8'hFE, fs: 1'b0};
    vecs[6] = '{rst_n: 1'b1, en: 1'b1, an: 8'hFE, seg: 8'hFE, fs: 1'b0};

    #2;
    for (int i = 0; i < 7; i++) begin
      reset  = vecs[i].rst_n;
      enable = vecs[i].en;
      step();
      check($sformatf("vec%0d an", i), 32'(bus.scan_an), 32'(vecs[i].an));
      check($sformatf("vec%0d seg", i), 32'(bus.scan_seg), 32'(vecs[i].seg));
      check($sformatf("vec%0d frame_start", i), 32'(bus.frame_start), 32'(vecs[i].fs));
    end

    // Slot 1 shows digit 1, and frame_start repeats every 8 slots.
    run_to(CLK_DIV + BLANK_CYC);
    check("slot1 an", 32'(bus.scan_an), 32'h0000_00FD);
    check("slot1 seg", 32'(bus.scan_seg), 32'h0000_00FD);
    run_to(0);
    check("frame_start pulse", 32'(bus.frame_start), 32'd1);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!bus.frame_start && cnt < FRAME + 8);
    check("frame period", 32'(cnt), 32'(FRAME));

    // Mid-frame seg_3 change is deferred to the next snapshot.
    seg[3] = 8'h01;
    run_to(0);
    run_to(CLK_DIV + 3);
    seg[3] = 8'h7F;
    run_to(3 * CLK_DIV + BLANK_CYC);
    check("seg3 same frame", 32'(bus.scan_seg), 32'h0000_00FE);
    run_to(0);
    run_to(3 * CLK_DIV + BLANK_CYC);
    check("seg3 next frame", 32'(bus.scan_seg), 32'h0000_0080);

    // Masked digits stay dark in their slots without changing the frame period.
    mask = 8'h0F;
    run_to(0);
    lit = 0;
    for (int i = 1; i < FRAME; i++) begin
      step();
      if (m_t >= 4 * CLK_DIV && bus.scan_an != 8'hFF) lit++;
    end
    check("masked slots dark", 32'(lit), 32'd0);
    step();
    check("masked frame period", 32'(bus.frame_start), 32'd1);
    mask = 8'hFF;

    // Disable during DRIVE of slot 5, then re-enable.
    run_to(5 * CLK_DIV + BLANK_CYC + 1);
    enable = 1'b0;
    step();
    check("disable off", {15'd0, bus.scan_an, bus.scan_seg, bus.frame_start}, {15'd0, 8'hFF, 8'hFF, 1'b0});
    step();
    step();
    step();
    enable = 1'b1;
    step();
    check("re-enable frame_start", 32'(bus.frame_start), 32'd1);
    check("re-enable blank", 32'(bus.scan_an), 32'h0000_00FF);
    run_to(BLANK_CYC);
    check("re-enable slot0 an", 32'(bus.scan_an), 32'h0000_00FE);

    // Reset mid-slot recovers the same way.
    run_to(2 * CLK_DIV + BLANK_CYC + 2);
    reset = 1'b0;
    step();
    check("mid reset off", {15'd0, bus.scan_an, bus.scan_seg, bus.frame_start}, {15'd0, 8'hFF, 8'hFF, 1'b0});
    reset = 1'b1;
    step();
    check("post reset frame_start", 32'(bus.frame_start), 32'd1);
    run_to(BLANK_CYC);
    check("post reset slot0", {16'd0, bus.scan_an, bus.scan_seg}, {16'd0, 8'hFE, 8'hFE});

`ifdef GPIO_SEG_DIM_EN
    // At brightness 4, four phases in each 16 are lit, so 8 of 32 DRIVE cycles; brightness 0 is dark.
    bright = 4'd4;
    run_to(0);
    lit = 0;
    for (int i = 0; i < CLK_DIV; i++) begin
      if (i > 0) step();
      if (bus.scan_an == 8'hFE) lit++;
    end
    check("dim4 lit cycles", 32'(lit), 32'd8);
    bright = 4'd0;
    step();
    lit = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (bus.scan_an != 8'hFF) lit++;
    end
    check("dim0 dark", 32'(lit), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
